// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared definitions: ALU command codes and FSM states.
// Imported by alu_arb_grant and alu_arbiter.
package alu_arb_pkg;

  localparam int ALU_ARB_WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-requester grant: fixed priority (req0) or, with macro
// ALU_ARB_ROUND_ROBIN_EN, a 1-bit round-robin pointer.
// Ports: valid_i[1:0], idle_i, grant_o[1:0] one-hot;
// clk_i, rst_ni, accept_i exist only in the round-robin build.
module alu_arb_grant
  import alu_arb_pkg::*;
(
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       accept_i,
`endif
  input  logic [1:0] valid_i,
  input  logic       idle_i,
  output logic [1:0] grant_o
);

  logic pref;
  logic win1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Point at whoever was not granted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  assign pref = ptr_q;
`else
  assign pref = 1'b0;
`endif

  // req1 wins when alone, or on a tie when preferred.
  assign win1 = valid_i[1] & (~valid_i[0] | pref);

  assign grant_o[1] = idle_i & win1;
  assign grant_o[0] = idle_i & valid_i[0] & ~win1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
// Ports: req{0,1}_* valid/ready ops in, alu_* to/from ALU,
// rsp_* response out, busy. Option: ALU_ARB_ROUND_ROBIN_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_ARB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_cmd,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             busy
);

  alu_arb_state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             id_q, id_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic             zr_q, zr_d;
  logic             ov_q, ov_d;

  logic       idle;
  logic [1:0] grant;
  logic       accept;

  assign idle   = (state_q == IDLE);
  assign accept = |grant;

  alu_arb_grant u_grant (
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .accept_i (accept),
`endif
    .valid_i  ({req1_valid, req0_valid}),
    .idle_i   (idle),
    .grant_o  (grant)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cmd_d   = cmd_q;
    id_d    = id_q;
    vld_d   = vld_q;
    res_d   = res_q;
    cy_d    = cy_q;
    zr_d    = zr_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          opa_d   = grant[1] ? req1_a   : req0_a;
          opb_d   = grant[1] ? req1_b   : req0_b;
          cmd_d   = grant[1] ? req1_cmd : req0_cmd;
          id_d    = grant[1];
        end
      end
      EXEC: begin
        state_d = RESP;
        res_d   = alu_result;
        cy_d    = alu_carryout;
        zr_d    = alu_zero;
        ov_d    = alu_overflow;
        vld_d   = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      zr_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cmd_q   <= cmd_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      zr_q    <= zr_d;
      ov_q    <= ov_d;
    end
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign alu_operandA = opa_q;
  assign alu_operandB = opb_q;
  assign alu_command  = cmd_q;
  assign rsp_valid    = vld_q;
  assign rsp_id       = id_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = cy_q;
  assign rsp_zero     = zr_q;
  assign rsp_overflow = ov_q;
  assign busy         = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU.
// Random and directed traffic; optional ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         o;
  } rsp_t;

  typedef struct {
    bit           v;
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_cmd = '0, req1_cmd = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic [W-1:0] alu_operandA, alu_operandB;
  logic [2:0]   alu_command;
  logic [W-1:0] alu_result;
  logic         alu_carryout, alu_zero, alu_overflow;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_carryout, rsp_zero, rsp_overflow;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  rsp_t sbq[$];
  bit   idlog[$];
  req_t p[2];

  // Reference model: phase 0 idle, 1 executing, 2 holding rsp.
  int           mphase = 0;
  bit           ptr = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_c = '0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_cmd     (req0_cmd),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_cmd     (req1_cmd),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_command  (alu_command),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carryout (rsp_carryout),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic rsp_t alu_fn(
    logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b);
    rsp_t e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        e.r = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  rsp_t alu_now;
  always_comb begin
    alu_now      = alu_fn(alu_command, alu_operandA, alu_operandB);
    alu_result   = alu_now.r;
    alu_carryout = alu_now.c;
    alu_zero     = alu_now.z;
    alu_overflow = alu_now.o;
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] exp_grant();
    bit v0, v1;
    v0 = p[0].v;
    v1 = p[1].v;
    if (mphase != 0) return 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ptr ? 2'b10 : 2'b01;
`endif
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 6)
      0: return '0;
      1: return 32'h7fff_ffff;
      2: return 32'h8000_0000;
      3: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(int i, logic [2:0] c,
                       logic [W-1:0] a, logic [W-1:0] b);
    p[i].v = 1'b1;
    p[i].c = c;
    p[i].a = a;
    p[i].b = b;
  endtask

  task automatic refill(int pct, int drop);
    for (int i = 0; i < 2; i++) begin
      if (!p[i].v && ($urandom % 100) < pct)
        issue(i, 3'($urandom), rnd_op(), rnd_op());
      else if (p[i].v && ($urandom % 100) < drop)
        p[i].v = 1'b0;
    end
  endtask

  // One clock: drive, check handshake outputs, advance model.
  task automatic step(input bit rr);
    bit [1:0] g;
    bit       w;
    rsp_t     e;
    @(negedge clk);
    req0_valid = p[0].v;
    req0_cmd   = p[0].c;
    req0_a     = p[0].a;
    req0_b     = p[0].b;
    req1_valid = p[1].v;
    req1_cmd   = p[1].c;
    req1_a     = p[1].a;
    req1_b     = p[1].b;
    rsp_ready  = rr;
    #1;
    g = exp_grant();
    chk("req0_ready", req0_ready, g[0]);
    chk("req1_ready", req1_ready, g[1]);
    chk("busy", busy, mphase != 0);
    chk("rsp_valid", rsp_valid, mphase == 2);
    chk("alu_opA", alu_operandA, m_a);
    chk("alu_opB", alu_operandB, m_b);
    chk("alu_cmd", alu_command, m_c);
    @(posedge clk);
    if (g != 2'b00) begin
      w = g[1];
      e = alu_fn(p[w].c, p[w].a, p[w].b);
      e.id = w;
      sbq.push_back(e);
      m_a = p[w].a;
      m_b = p[w].b;
      m_c = p[w].c;
      ptr = ~w;
      p[w].v = 1'b0;
      mphase = 1;
    end else if (mphase == 1) begin
      mphase = 2;
    end else if (mphase == 2 && rr) begin
      mphase = 0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!p[0].v && !p[1].v && mphase == 0) begin
        done = 1'b1;
        break;
      end
      step(1'b1);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: phase %0d", mphase);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_opA"}, alu_operandA, 0);
    chk({n, "_opB"}, alu_operandB, 0);
    chk({n, "_cmd"}, alu_command, 0);
    chk({n, "_rsp"},
        {rsp_valid, rsp_id, rsp_carryout,
         rsp_zero, rsp_overflow, busy}, 0);
    chk({n, "_res"}, rsp_result, 0);
    chk({n, "_rdy"}, {req0_ready, req1_ready}, 0);
  endtask

  task automatic model_reset();
    sbq.delete();
    mphase = 0;
    ptr = 1'b0;
    m_a = '0;
    m_b = '0;
    m_c = '0;
    p[0].v = 1'b0;
    p[1].v = 1'b0;
  endtask

  // Monitor: pops on each new response, then checks it is held.
  initial begin : monitor
    bit   have;
    rsp_t cur;
    have = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        have = 1'b0;
      end else if (rsp_valid) begin
        if (!have) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_unexpected: id %0d res %0h",
                     rsp_id, rsp_result);
          end else begin
            cur = sbq.pop_front();
            have = 1'b1;
            idlog.push_back(rsp_id);
          end
        end
        if (have) begin
          chk("rsp_id", rsp_id, cur.id);
          chk("rsp_result", rsp_result, cur.r);
          chk("rsp_flags",
              {rsp_carryout, rsp_zero, rsp_overflow},
              {cur.c, cur.z, cur.o});
        end
        if (rsp_ready) have = 1'b0;
      end
    end
  end

  initial begin : driver
    bit exp_ids[4];
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the arbiter's intended use.
    issue(0, 3'd0, 32'd7, 32'd5);
    drain();
    issue(1, 3'd0, 32'h7fff_ffff, 32'd1);
    drain();
    issue(0, 3'd1, 32'd3, 32'd3);
    drain();
    issue(0, 3'd1, 32'd5, 32'd7);
    drain();

    // Backpressure: hold the response, loser waits.
    issue(0, 3'd2, 32'hf0f0_1234, 32'h0ff0_4321);
    issue(1, 3'd3, 32'h8000_0000, 32'd1);
    for (int i = 0; i < 6 && mphase != 2; i++) step(1'b0);
    repeat (5) step(1'b0);
    step(1'b1);
    step(1'b1);
    drain();

    // Reset during EXEC discards the op and the pointer.
    issue(0, 3'd4, 32'hffff_0000, 32'h0f0f_0f0f);
    step(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk_zero("rst_exec");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b1);

    // Contention: both requesters always valid.
    idlog.delete();
    for (int i = 0; i < 13; i++) begin
      refill(100, 0);
      step(1'b1);
    end
    p[0].v = 1'b0;
    p[1].v = 1'b0;
    drain();
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    chk("contention_count", idlog.size() >= 4, 1);
    for (int k = 0; k < 4 && k < idlog.size(); k++)
      chk($sformatf("contention_id%0d", k), idlog[k], exp_ids[k]);

    // Random traffic with drops and backpressure.
    for (int i = 0; i < 800; i++) begin
      refill(40, 5);
      step(($urandom % 100) < 70);
    end
    p[0].v = 1'b0;
    p[1].v = 1'b0;
    drain();
    step(1'b1);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one combinational 32-bit ALU between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the shared ALU from registered operands. It captures result and flags into a response register, then holds the response until the consumer accepts it. It sits between the register-read stage of each client and the `ALU` instance; the ALU's ports connect directly to this block's `alu_*` ports.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester N presents an operation.
- `req0_ready` / `req1_ready`  out  1  the operation is accepted on the rising edge where valid&ready.
- `req0_cmd` / `req1_cmd`  in  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_operandA`, `alu_operandB`  out  WIDTH  registered operands to the ALU.
- `alu_command`  out  3  registered command to the ALU.
- `alu_result`  in  WIDTH  ALU result.
- `alu_carryout`, `alu_zero`, `alu_overflow`  in  1  ALU flags.
- `rsp_valid`  out  1  a response is held.
- `rsp_ready`  in  1  consumer accepts the response on valid&ready.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_carryout`, `rsp_zero`, `rsp_overflow`  out  1  captured flags.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:** `reqN_ready` is combinational and high only for the granted valid requester; the other requester's ready is 0.
  - On the handshake edge, latch cmd/a/b into the operand registers, record `rsp_id`, and go to EXEC.
  - With no valid request, stay in IDLE; all ready signals are 0.
- **EXEC (exactly 1 cycle):** the ALU sees the latched operands. On the next edge, capture `alu_result` and the three flags into the `rsp_*` registers, set `rsp_valid`, and go to RESP.
- **RESP:** hold all `rsp_*` signals stable. On rsp_valid&rsp_ready, clear `rsp_valid` and go to IDLE. All `reqN_ready` signals are 0 in EXEC and RESP.
- Operand registers hold their last value between operations; they change only on an accept.
- Requesters must not make valid depend on ready. A requester may drop valid before it is granted.
- Grant policy: see Configuration.
- **Reset** (any state, including mid-EXEC or mid-RESP):
  - FSM returns to IDLE; the in-flight operation is discarded with no response.
  - All outputs go to 0, including `alu_*`, `rsp_*`, `busy`, `reqN_ready` (in IDLE, ready then follows the grant logic), and the round-robin pointer.
- Width rule: results and flags pass through unmodified; the block performs no arithmetic.

## Timing
- Accept edge T → `rsp_valid` high after edge T+1 (response latency 2 cycles from the cycle where valid is first seen with ready).
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with `rsp_ready` held high).
- Response accepted at edge R → IDLE in cycle R; the next accept can occur at edge R+1.
- Simultaneous valid on both ports in IDLE: exactly one grant, chosen by the policy. The loser keeps valid and is considered again in the next IDLE cycle.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit priority pointer selects the preferred requester; it resets to 0, preferring req0.
  - After each grant, the pointer points to the non-granted requester.
  - A requester holding valid is granted within 2 operations.
- Not defined: fixed priority; req0 always wins a tie, and req1 can be starved. The pointer register is not built.

## Structure
- Package `alu_arb_pkg`:
  - 3-bit command encodings `ALU_ADD` … `ALU_OR`, matching the ALU.
  - State enum `alu_arb_state_t` {IDLE, EXEC, RESP}.
- Sub-module `alu_arb_grant`: two-input combinational grant plus the optional pointer register. Inputs: valids, state==IDLE, accept. Outputs: one-hot grant.
- The top level holds the FSM, operand registers and response registers.

## Test plan
- ADD: req0 cmd=0, a=7, b=5 → `rsp_valid` two edges after accept; rsp_result=12, rsp_id=0, zero=0, overflow=0.
- Overflow: req1 ADD a=0x7FFFFFFF, b=1 → rsp_result=0x80000000, overflow=1, carryout=0, rsp_id=1.
- SUB to zero: req0 cmd=1, a=3, b=3 → rsp_result=0, zero=1. Also SUB a=5, b=7 → 0xFFFFFFFE, carryout=0.
- Contention: both valid continuously from reset with `rsp_ready`=1.
  - With `ALU_ARB_ROUND_ROBIN_EN`: rsp_id sequence is 0,1,0,1.
  - Without it: 0,0,0,0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, both readys 0, `busy`=1. Raise `rsp_ready` → IDLE next cycle, and a pending request is accepted the following edge.
- Reset mid-EXEC: assert `rst_n`=0 during EXEC → all outputs 0 immediately, no response ever appears for that operation, and the pointer resets to req0.
